// File: rtl/tpm_buf_pkg.sv
// Shared types and constants for the TPM command/response buffer arbiter.
// Holds the ownership state encoding and the byte-lane geometry of the 32-bit RAM word.
package tpm_buf_pkg;

    typedef enum logic [1:0] {
        S_DP  = 2'd0,
        S_WB  = 2'd1,
        S_CPL = 2'd2
    } buf_state_e;

    localparam logic [31:0] DFLT_READ_VALUE           = 32'hBADFABAC;
    localparam int          DFLT_COMPLETE_PULSE_WIDTH = 20;

    localparam int LANE_BITS      = 8;
    localparam int NUM_LANES      = 4;
    localparam int LANE_SEL_WIDTH = 2;

endpackage

// File: rtl/tpm_buf_arbiter_if.sv
// Byte-wide data-provider port and 32-bit Wishbone port of the TPM buffer.
// The master modport is the requesting side and the slave modport is the arbiter.
interface tpm_buf_arbiter_if #(
    parameter int RAM_ADDR_WIDTH = 11
);
    logic                      dp_req_i;
    logic                      dp_we_i;
    logic [RAM_ADDR_WIDTH-1:0] dp_addr_i;
    logic [7:0]                dp_wdata_i;
    logic [7:0]                dp_rdata_o;
    logic                      dp_ack_o;

    logic                      wb_cyc_i;
    logic                      wb_stb_i;
    logic                      wb_we_i;
    logic [RAM_ADDR_WIDTH-3:0] wb_adr_i;
    logic [3:0]                wb_sel_i;
    logic [31:0]               wb_dat_i;
    logic [31:0]               wb_dat_o;
    logic                      wb_ack_o;

    modport master (
        output dp_req_i, dp_we_i, dp_addr_i, dp_wdata_i,
        input  dp_rdata_o, dp_ack_o,
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  dp_req_i, dp_we_i, dp_addr_i, dp_wdata_i,
        output dp_rdata_o, dp_ack_o,
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/dp_byte_lane.sv
// Places a data-provider byte onto its lane of a 32-bit RAM word and extracts
// a byte back out of a read word; purely combinational, keyed by addr[1:0].
module dp_byte_lane
    import tpm_buf_pkg::*;
(
    input  logic [LANE_SEL_WIDTH-1:0]      wr_lane,
    input  logic [LANE_BITS-1:0]           wr_byte,
    output logic [NUM_LANES*LANE_BITS-1:0] wr_word,
    output logic [NUM_LANES-1:0]           wr_en,
    input  logic [LANE_SEL_WIDTH-1:0]      rd_lane,
    input  logic [NUM_LANES*LANE_BITS-1:0] rd_word,
    output logic [LANE_BITS-1:0]           rd_byte
);

    // Unselected lanes stay zero so the RAM sees a clean one-hot write.
    always_comb begin
        wr_word = '0;
        wr_en   = '0;
        wr_word[wr_lane*LANE_BITS +: LANE_BITS] = wr_byte;
        wr_en[wr_lane] = 1'b1;
        rd_byte = rd_word[rd_lane*LANE_BITS +: LANE_BITS];
    end

endmodule

// File: rtl/tpm_buf_arbiter.sv
// Owns the 512x32 TPM buffer RAM and hands it between the LPC data provider and
// the M4 Wishbone side through the exec / abort / complete handshake.
module tpm_buf_arbiter #(
    parameter int          RAM_ADDR_WIDTH       = 11,
    parameter int          COMPLETE_PULSE_WIDTH = tpm_buf_pkg::DFLT_COMPLETE_PULSE_WIDTH,
    parameter logic [31:0] DEFAULT_READ_VALUE   = tpm_buf_pkg::DFLT_READ_VALUE
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    tpm_buf_arbiter_if.slave          bus,
    input  logic                      exec_req_i,
    input  logic                      abort_req_i,
    input  logic                      complete_req_i,
    output logic                      exec_o,
    output logic                      abort_o,
    output logic                      complete_o,
    output logic [RAM_ADDR_WIDTH-3:0] ram_a_o,
    output logic [31:0]               ram_wd_o,
    output logic [3:0]                ram_wen_o,
    input  logic [31:0]               ram_rd_i
);
    import tpm_buf_pkg::*;

    localparam int CNT_W = $clog2(COMPLETE_PULSE_WIDTH + 1);

    buf_state_e        state_q, state_d;
    logic              exec_pending_q, exec_pending_d;
    logic              exec_q, exec_d;
    logic              abort_q, abort_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              dp_ack_q;
    logic [1:0]        dp_lane_q;
    logic              wb_ack_q;
    logic              wb_own_q;
    logic              dp_accept;
    logic              wb_accept;
    logic              state_change;
    logic [31:0]       lane_wr_word;
    logic [3:0]        lane_wr_en;
    logic [7:0]        lane_rd_byte;

    // The ack cycle blocks a new accept, which also gives ownership a free slot to move.
    assign dp_accept    = !rst_i && (state_q == S_DP) && bus.dp_req_i && !dp_ack_q;
    assign wb_accept    = !rst_i && bus.wb_cyc_i && bus.wb_stb_i && !wb_ack_q;
    assign state_change = (state_d != state_q);

    dp_byte_lane u_lane (
        .wr_lane (bus.dp_addr_i[1:0]),
        .wr_byte (bus.dp_wdata_i),
        .wr_word (lane_wr_word),
        .wr_en   (lane_wr_en),
        .rd_lane (dp_lane_q),
        .rd_word (ram_rd_i),
        .rd_byte (lane_rd_byte)
    );

    always_comb begin
        state_d        = state_q;
        exec_pending_d = exec_pending_q;
        exec_d         = exec_q;
        abort_d        = abort_q;
        count_d        = count_q;
        case (state_q)
            S_DP: begin
                exec_pending_d = exec_pending_q | exec_req_i;
                if (exec_pending_d && !dp_accept) begin
                    state_d        = S_WB;
                    exec_pending_d = 1'b0;
                    exec_d         = 1'b1;
                end
            end
            S_WB: begin
                if (complete_req_i) begin
                    state_d = S_CPL;
                    count_d = CNT_W'(COMPLETE_PULSE_WIDTH);
                    exec_d  = 1'b0;
                    abort_d = 1'b0;
                end else if (abort_req_i) begin
                    abort_d = 1'b1;
                end
            end
            S_CPL: begin
                if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    state_d = S_DP;
                end
            end
            default: state_d = S_DP;
        endcase
    end

    // Writes are suppressed on the cycle ownership moves so no side writes across a handover.
    always_comb begin
        ram_a_o   = bus.dp_addr_i[RAM_ADDR_WIDTH-1:2];
        ram_wd_o  = lane_wr_word;
        ram_wen_o = '0;
        if (state_q == S_WB) begin
            ram_a_o  = bus.wb_adr_i;
            ram_wd_o = bus.wb_dat_i;
            if (wb_accept && bus.wb_we_i && !state_change) begin
                ram_wen_o = bus.wb_sel_i;
            end
        end else if (dp_accept && bus.dp_we_i && !state_change) begin
            ram_wen_o = lane_wr_en;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_DP;
            exec_pending_q <= 1'b0;
            exec_q         <= 1'b0;
            abort_q        <= 1'b0;
            count_q        <= '0;
            dp_ack_q       <= 1'b0;
            dp_lane_q      <= '0;
            wb_ack_q       <= 1'b0;
            wb_own_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            exec_pending_q <= exec_pending_d;
            exec_q         <= exec_d;
            abort_q        <= abort_d;
            count_q        <= count_d;
            dp_ack_q       <= dp_accept;
            wb_ack_q       <= wb_accept;
            if (dp_accept) begin
                dp_lane_q <= bus.dp_addr_i[1:0];
            end
            if (wb_accept) begin
                wb_own_q <= (state_q == S_WB);
            end
        end
    end

    assign exec_o         = exec_q;
    assign abort_o        = abort_q;
    assign complete_o     = (state_q == S_CPL) && (count_q != '0);
    assign bus.dp_ack_o   = dp_ack_q;
    assign bus.dp_rdata_o = lane_rd_byte;
    assign bus.wb_ack_o   = wb_ack_q;
    assign bus.wb_dat_o   = wb_own_q ? ram_rd_i : DEFAULT_READ_VALUE;

endmodule

// File: tb/tb_tpm_buf_arbiter.sv
// Self-checking bench for tpm_buf_arbiter: a behavioural 512x32 RAM, scoreboard
// queues for DP and WB read data, and one task per scenario.
module tb_tpm_buf_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        exec_req, abort_req, complete_req;
    logic        exec_o, abort_o, complete_o;
    logic [8:0]  ram_a;
    logic [31:0] ram_wd;
    logic [3:0]  ram_wen;
    logic [31:0] ram_rd;
    logic        mem_clr;
    logic [31:0] mem [0:511];

    int total = 0;
    int bad   = 0;

    logic [7:0]  dp_exp_q [$];
    logic [31:0] wb_exp_q [$];

    tpm_buf_arbiter_if #(.RAM_ADDR_WIDTH(11)) bus ();

    tpm_buf_arbiter #(
        .RAM_ADDR_WIDTH       (11),
        .COMPLETE_PULSE_WIDTH (20),
        .DEFAULT_READ_VALUE   (32'hBADFABAC)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus),
        .exec_req_i     (exec_req),
        .abort_req_i    (abort_req),
        .complete_req_i (complete_req),
        .exec_o         (exec_o),
        .abort_o        (abort_o),
        .complete_o     (complete_o),
        .ram_a_o        (ram_a),
        .ram_wd_o       (ram_wd),
        .ram_wen_o      (ram_wen),
        .ram_rd_i       (ram_rd)
    );

    always #5 clk = ~clk;

    // Behavioural RAM with byte enables and a one-cycle synchronous read.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wen[b]) mem[ram_a][b*8 +: 8] <= ram_wd[b*8 +: 8];
            end
        end
        ram_rd <= mem[ram_a];
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic wait_dp_ack(input int budget, output int cycles, output logic seen);
        seen = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.dp_ack_o) seen = 1'b1;
        end
    endtask

    task automatic wait_wb_ack(input int budget, output int cycles, output logic seen);
        seen = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.wb_ack_o) seen = 1'b1;
        end
    endtask

    task automatic idle_inputs;
        bus.dp_req_i   = 1'b0;
        bus.dp_we_i    = 1'b0;
        bus.dp_addr_i  = '0;
        bus.dp_wdata_i = '0;
        bus.wb_cyc_i   = 1'b0;
        bus.wb_stb_i   = 1'b0;
        bus.wb_we_i    = 1'b0;
        bus.wb_adr_i   = '0;
        bus.wb_sel_i   = '0;
        bus.wb_dat_i   = '0;
        exec_req       = 1'b0;
        abort_req      = 1'b0;
        complete_req   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mem_clr = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({exec_o, abort_o, complete_o, bus.dp_ack_o, bus.wb_ack_o, ram_wen} !== 9'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%b want=0", {exec_o, abort_o, complete_o, bus.dp_ack_o, bus.wb_ack_o, ram_wen});
        end
        rst = 1'b0;
        mem_clr = 1'b0;
    endtask

    task automatic test_dp_write_read;
        int cyc;
        logic seen;
        logic [7:0] exp;
        @(negedge clk);
        bus.dp_req_i = 1'b1; bus.dp_we_i = 1'b1; bus.dp_addr_i = 11'h006; bus.dp_wdata_i = 8'h5A;
        #1;
        total++;
        if (ram_wen !== 4'b0100) begin bad++; $display("[TB] FAIL dp_wr_wen got=%b want=0100", ram_wen); end
        total++;
        if (ram_a !== 9'd1) begin bad++; $display("[TB] FAIL dp_wr_addr got=%0d want=1", ram_a); end
        total++;
        if (ram_wd !== 32'h005A0000) begin bad++; $display("[TB] FAIL dp_wr_data got=%h want=005a0000", ram_wd); end
        wait_dp_ack(4, cyc, seen);
        total++;
        if (!seen || cyc != 1) begin bad++; $display("[TB] FAIL dp_wr_ack seen=%0d latency=%0d want latency=1", seen, cyc); end
        bus.dp_req_i = 1'b0; bus.dp_we_i = 1'b0;
        @(negedge clk);
        total++;
        if (mem[1] !== 32'h005A0000) begin bad++; $display("[TB] FAIL dp_wr_mem got=%h want=005a0000", mem[1]); end
        bus.dp_req_i = 1'b1; bus.dp_addr_i = 11'h006;
        dp_exp_q.push_back(8'h5A);
        wait_dp_ack(4, cyc, seen);
        total++;
        if (!seen || cyc != 1) begin bad++; $display("[TB] FAIL dp_rd_ack seen=%0d latency=%0d want latency=1", seen, cyc); end
        if (seen) begin
            exp = dp_exp_q.pop_front();
            total++;
            if (bus.dp_rdata_o !== exp) begin bad++; $display("[TB] FAIL dp_rd_data got=%h want=%h", bus.dp_rdata_o, exp); end
        end
        bus.dp_req_i = 1'b0;
    endtask

    task automatic test_wb_non_owner;
        int cyc;
        logic seen;
        logic [31:0] exp;
        @(negedge clk);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 9'd1; bus.wb_sel_i = 4'hF;
        wb_exp_q.push_back(32'hBADFABAC);
        wb_exp_q.push_back(32'hBADFABAC);
        #1;
        total++;
        if (ram_wen !== 4'b0) begin bad++; $display("[TB] FAIL wb_nonown_rd_wen got=%b want=0000", ram_wen); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (bus.wb_ack_o !== 1'((k % 2) == 1)) begin
                bad++;
                $display("[TB] FAIL wb_ack_pattern k=%0d got=%b want=%b", k, bus.wb_ack_o, (k % 2) == 1);
            end
            if (bus.wb_ack_o && wb_exp_q.size() > 0) begin
                exp = wb_exp_q.pop_front();
                total++;
                if (bus.wb_dat_o !== exp) begin bad++; $display("[TB] FAIL wb_nonown_data got=%h want=%h", bus.wb_dat_o, exp); end
            end
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        wb_exp_q.delete();
        @(negedge clk);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1; bus.wb_adr_i = 9'd1; bus.wb_dat_i = 32'hFFFFFFFF;
        #1;
        total++;
        if (ram_wen !== 4'b0) begin bad++; $display("[TB] FAIL wb_nonown_wr_wen got=%b want=0000", ram_wen); end
        wait_wb_ack(4, cyc, seen);
        total++;
        if (!seen || cyc != 1) begin bad++; $display("[TB] FAIL wb_nonown_wr_ack seen=%0d latency=%0d want latency=1", seen, cyc); end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        @(negedge clk);
        total++;
        if (mem[1] !== 32'h005A0000) begin bad++; $display("[TB] FAIL wb_nonown_mem got=%h want=005a0000", mem[1]); end
    endtask

    task automatic test_exec_wb_read;
        int cyc;
        int early;
        logic seen;
        logic [31:0] exp;
        @(negedge clk);
        exec_req = 1'b1;
        @(negedge clk);
        exec_req = 1'b0;
        total++;
        if (exec_o !== 1'b1) begin bad++; $display("[TB] FAIL exec_rise got=%b want=1", exec_o); end
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 9'd1; bus.wb_sel_i = 4'hF;
        wb_exp_q.push_back(32'h005A0000);
        wait_wb_ack(4, cyc, seen);
        total++;
        if (!seen || cyc != 1) begin bad++; $display("[TB] FAIL wb_own_rd_ack seen=%0d latency=%0d want latency=1", seen, cyc); end
        if (seen) begin
            exp = wb_exp_q.pop_front();
            total++;
            if (bus.wb_dat_o !== exp) begin bad++; $display("[TB] FAIL wb_own_rd_data got=%h want=%h", bus.wb_dat_o, exp); end
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        @(negedge clk);
        bus.dp_req_i = 1'b1; bus.dp_we_i = 1'b0; bus.dp_addr_i = 11'h006;
        dp_exp_q.push_back(8'h5A);
        early = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.dp_ack_o) early++;
        end
        total++;
        if (early != 0) begin bad++; $display("[TB] FAIL dp_stall_in_wb acks=%0d want=0", early); end
    endtask

    task automatic test_abort_complete;
        int cyc;
        int hi;
        int early;
        logic seen;
        logic [7:0] exp;
        @(negedge clk);
        abort_req = 1'b1;
        @(negedge clk);
        abort_req = 1'b0;
        total++;
        if (abort_o !== 1'b1) begin bad++; $display("[TB] FAIL abort_set got=%b want=1", abort_o); end
        repeat (2) @(negedge clk);
        complete_req = 1'b1;
        #1;
        total++;
        if (abort_o !== 1'b1) begin bad++; $display("[TB] FAIL abort_hold got=%b want=1", abort_o); end
        hi = 0;
        early = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                complete_req = 1'b0;
                total++;
                if ({exec_o, abort_o} !== 2'b00) begin
                    bad++;
                    $display("[TB] FAIL cpl_clears got exec/abort=%b want=00", {exec_o, abort_o});
                end
            end
            if (bus.dp_ack_o) early++;
            if (complete_o) hi++;
            else if (hi > 0) break;
        end
        total++;
        if (hi != 20) begin bad++; $display("[TB] FAIL complete_width got=%0d want=20", hi); end
        total++;
        if (early != 0) begin bad++; $display("[TB] FAIL dp_stall_in_cpl acks=%0d want=0", early); end
        wait_dp_ack(3, cyc, seen);
        total++;
        if (!seen || cyc > 2) begin bad++; $display("[TB] FAIL dp_resume_ack seen=%0d latency=%0d want<=2", seen, cyc); end
        if (seen) begin
            exp = dp_exp_q.pop_front();
            total++;
            if (bus.dp_rdata_o !== exp) begin bad++; $display("[TB] FAIL dp_resume_data got=%h want=%h", bus.dp_rdata_o, exp); end
        end
        bus.dp_req_i = 1'b0;
    endtask

    task automatic test_exec_with_dp_write;
        int cyc;
        logic seen;
        logic [31:0] exp;
        @(negedge clk);
        bus.dp_req_i = 1'b1; bus.dp_we_i = 1'b1; bus.dp_addr_i = 11'h00B; bus.dp_wdata_i = 8'hC3;
        exec_req = 1'b1;
        #1;
        total++;
        if (ram_wen !== 4'b1000 || ram_a !== 9'd2) begin
            bad++;
            $display("[TB] FAIL dp_exec_wr got wen=%b addr=%0d want wen=1000 addr=2", ram_wen, ram_a);
        end
        @(negedge clk);
        exec_req = 1'b0;
        total++;
        if ({bus.dp_ack_o, exec_o} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL dp_exec_ack got ack/exec=%b want=10", {bus.dp_ack_o, exec_o});
        end
        bus.dp_req_i = 1'b0; bus.dp_we_i = 1'b0;
        @(negedge clk);
        total++;
        if (exec_o !== 1'b1) begin bad++; $display("[TB] FAIL exec_after_ack got=%b want=1", exec_o); end
        total++;
        if (mem[2] !== 32'hC3000000) begin bad++; $display("[TB] FAIL dp_exec_mem got=%h want=c3000000", mem[2]); end
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 9'd2; bus.wb_sel_i = 4'hF;
        wb_exp_q.push_back(32'hC3000000);
        wait_wb_ack(4, cyc, seen);
        total++;
        if (!seen || cyc != 1) begin bad++; $display("[TB] FAIL wb_rd2_ack seen=%0d latency=%0d want latency=1", seen, cyc); end
        if (seen) begin
            exp = wb_exp_q.pop_front();
            total++;
            if (bus.wb_dat_o !== exp) begin bad++; $display("[TB] FAIL wb_rd2_data got=%h want=%h", bus.wb_dat_o, exp); end
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        @(negedge clk);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1; bus.wb_adr_i = 9'd3;
        bus.wb_sel_i = 4'b0011; bus.wb_dat_i = 32'h12345678;
        #1;
        total++;
        if (ram_wen !== 4'b0011) begin bad++; $display("[TB] FAIL wb_own_wr_wen got=%b want=0011", ram_wen); end
        wait_wb_ack(4, cyc, seen);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        @(negedge clk);
        total++;
        if (mem[3] !== 32'h00005678) begin bad++; $display("[TB] FAIL wb_own_wr_mem got=%h want=00005678", mem[3]); end
    endtask

    task automatic test_reset_in_cpl;
        int cyc;
        int hi;
        logic seen;
        logic [7:0] exp8;
        logic [31:0] exp32;
        @(negedge clk);
        complete_req = 1'b1;
        abort_req = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) begin
                complete_req = 1'b0;
                abort_req = 1'b0;
                total++;
                if ({abort_o, complete_o} !== 2'b01) begin
                    bad++;
                    $display("[TB] FAIL cpl_beats_abort got abort/complete=%b want=01", {abort_o, complete_o});
                end
            end
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({exec_o, abort_o, complete_o, bus.dp_ack_o, bus.wb_ack_o, ram_wen} !== 9'b0) begin
            bad++;
            $display("[TB] FAIL reset_in_cpl got=%b want=0", {exec_o, abort_o, complete_o, bus.dp_ack_o, bus.wb_ack_o, ram_wen});
        end
        rst = 1'b0;
        @(negedge clk);
        complete_req = 1'b1;
        @(negedge clk);
        complete_req = 1'b0;
        hi = 0;
        repeat (3) begin
            @(negedge clk);
            if (complete_o) hi++;
        end
        total++;
        if (hi != 0) begin bad++; $display("[TB] FAIL cpl_ignored_in_dp got=%0d want=0", hi); end
        bus.dp_req_i = 1'b1; bus.dp_we_i = 1'b0; bus.dp_addr_i = 11'h00B;
        dp_exp_q.push_back(8'hC3);
        wait_dp_ack(4, cyc, seen);
        total++;
        if (!seen || cyc != 1) begin bad++; $display("[TB] FAIL dp_after_rst_ack seen=%0d latency=%0d want latency=1", seen, cyc); end
        if (seen) begin
            exp8 = dp_exp_q.pop_front();
            total++;
            if (bus.dp_rdata_o !== exp8) begin bad++; $display("[TB] FAIL dp_after_rst_data got=%h want=%h", bus.dp_rdata_o, exp8); end
        end
        bus.dp_req_i = 1'b0;
        @(negedge clk);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 9'd2; bus.wb_sel_i = 4'hF;
        wb_exp_q.push_back(32'hBADFABAC);
        wait_wb_ack(4, cyc, seen);
        total++;
        if (!seen) begin bad++; $display("[TB] FAIL wb_after_rst_ack seen=0 want=1"); end
        if (seen) begin
            exp32 = wb_exp_q.pop_front();
            total++;
            if (bus.wb_dat_o !== exp32) begin bad++; $display("[TB] FAIL wb_after_rst_data got=%h want=%h", bus.wb_dat_o, exp32); end
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        mem_clr = 1'b1;
        test_reset();
        test_dp_write_read();
        test_wb_non_owner();
        test_exec_wb_read();
        test_abort_complete();
        test_exec_with_dp_write();
        test_reset_in_cpl();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tpm_buf_arbiter.md
Name: tpm_buf_arbiter

Overview:
- Single-clock controller that owns the 512x32 TPM command/response RAM.
- Sequences buffer ownership between the LPC-side data provider (byte port) and the M4 Wishbone side (32-bit port) through an exec / abort / complete handshake.
- Replaces the exec-driven clock/data mux in the top level with synchronous arbitration.
- Sits between regs_module, the WB slave decode and the r512x32_512x32 RAM; all inputs are already in the clk_i domain.

Parameters:
- RAM_ADDR_WIDTH, 11: byte address width of the buffer; word address is RAM_ADDR_WIDTH-2 bits.
- COMPLETE_PULSE_WIDTH, 20: cycles complete_o stays high.
- DEFAULT_READ_VALUE, 32'hBADFABAC: WB read data returned while WB does not own the buffer.

Ports:
- clk_i  in  1  RAM/WB clock.
- rst_i  in  1  synchronous active-high reset.
- dp_req_i  in  1  DP access request; held until dp_ack_o.
- dp_we_i  in  1  DP write (1) / read (0).
- dp_addr_i  in  RAM_ADDR_WIDTH  DP byte address.
- dp_wdata_i  in  8  DP write byte.
- dp_rdata_o  out  8  DP read byte; valid with dp_ack_o.
- dp_ack_o  out  1  one-cycle DP completion.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  WB cycle/strobe/write, already decoded for RAM space.
- wb_adr_i  in  RAM_ADDR_WIDTH-2  WB word address.
- wb_sel_i  in  4  WB byte strobes.
- wb_dat_i  in  32  WB write data.
- wb_dat_o  out  32  WB read data.
- wb_ack_o  out  1  WB acknowledge.
- exec_req_i  in  1  pulse from regs_module: command ready for M4.
- abort_req_i  in  1  pulse: host abort.
- complete_req_i  in  1  pulse: M4 wrote COMPLETE register.
- exec_o, abort_o, complete_o  out  1 each  status / FB_msg_out bits.
- ram_a_o  out  RAM_ADDR_WIDTH-2  RAM word address.
- ram_wd_o  out  32  RAM write data.
- ram_wen_o  out  4  RAM byte write enables, active high.
- ram_rd_i  in  32  RAM read data; 1-cycle synchronous read.

Behaviour:
- Reset values:
  - FSM=S_DP; exec_o, abort_o, complete_o, dp_ack_o, wb_ack_o = 0.
  - ram_wen_o = 0; pulse counter 0; exec_pending 0.
  - Reset mid-access drops the access with no ack and no write.
- FSM states and transitions:
  - S_DP: DP owns RAM.
    - exec_req_i sets exec_pending.
    - Go to S_WB when exec_pending and no DP access in flight; exec_o=1 from that cycle.
  - S_WB: WB owns RAM; DP requests stall (no ack).
    - abort_req_i sets abort_o.
    - complete_req_i loads counter = COMPLETE_PULSE_WIDTH, clears exec_o and abort_o, goes to S_CPL.
  - S_CPL: complete_o=1 while counter != 0; counter decrements by 1 per cycle. Go to S_DP when counter reaches 0; complete_o is low that cycle.
- Ignored / priority cases:
  - complete_req_i in S_DP or S_CPL is ignored.
  - abort_req_i outside S_WB is ignored.
  - complete_req_i and abort_req_i in the same cycle: complete wins and abort_o ends 0.
  - exec_req_i while exec_pending=1 or in S_WB/S_CPL is ignored.
- DP access, owner only:
  - Cycle N: req sampled; ram_a_o = dp_addr_i[RAM_ADDR_WIDTH-1:2].
  - Write: ram_wd_o = dp_wdata_i placed on lane dp_addr_i[1:0] (lane 0 = bits 7:0), other lanes zero; ram_wen_o one-hot on that lane.
  - Cycle N+1: dp_ack_o=1; dp_rdata_o = ram_rd_i lane selected by registered addr[1:0].
  - No new DP access is accepted in the ack cycle, so the minimum is 2 cycles per access.
- WB access:
  - Accepted when cyc&stb&~wb_ack_o.
  - Owner: ram_wen_o = wb_we_i ? wb_sel_i : 0; wb_ack_o at N+1; wb_dat_o = ram_rd_i.
  - Non-owner: wb_ack_o still asserted at N+1 (the bus must never hang), ram_wen_o = 0, wb_dat_o = DEFAULT_READ_VALUE.
  - wb_ack_o is one cycle, then low for at least one cycle.
- RAM port mux:
  - Driven only by the current owner; other port inputs are don't-care.
  - ram_wen_o is 0 on any cycle where FSM state changes.
- Counter width is ceil(log2(COMPLETE_PULSE_WIDTH+1)); no wrap, holds at 0.

Decomposition:
- Package tpm_buf_pkg holds:
  - state enum (S_DP, S_WB, S_CPL);
  - DEFAULT_READ_VALUE;
  - COMPLETE_PULSE_WIDTH default;
  - lane-select helper constants.
- Sub-module dp_byte_lane: combinational byte to 32-bit lane placement, wen one-hot, and read lane extract, keyed by addr[1:0].

Test Plan:
- DP write 0x5A to byte 0x006, then read it back. Required: ram_wen_o=4'b0100 and ram_a_o=1 on the write; read returns 0x5A with dp_ack_o one cycle after the request.
- exec_req_i pulse, then WB read of word 1. Required: exec_o=1 next cycle; wb_dat_o bits 23:16 = 0x5A. A DP request raised now gets no dp_ack_o until ownership returns.
- WB read while in S_DP. Required: wb_ack_o at N+1, wb_dat_o=0xBADFABAC, no RAM write. WB write with sel=4'hF in S_DP leaves the RAM unchanged.
- In S_WB: abort_req_i, then complete_req_i. Required: abort_o=1 until the complete cycle; complete_o high exactly 20 cycles; the stalled DP request acks within 2 cycles after return to S_DP.
- exec_req_i in the same cycle as a DP write. Required: the write commits and acks; exec_o rises the cycle after the ack.
- rst_i asserted in S_CPL with counter=7. Required: next cycle all outputs are 0 and state is S_DP; a later complete_req_i is ignored.
